icg_multi_holdoff: RTL and testbench
====================================

# icg_multi_holdoff

Multi-channel integrated clock gate with per-channel programmable hold-off. It is the parametrised successor to the single test-enabled clock gate cell. N independent gated clocks are derived from one source clock. Each channel opens on its enable request and stays open for a programmable number of extra clock pulses after the request drops, so short gaps in activity do not toggle the gate. It sits at the root of a clock-gating domain, between the clock tree and N leaf register banks, and exposes per-channel activity status for power management.

## Interface
- N, default 4: number of gated clock channels (1..32).
- HOLD_W, default 4: width of the hold-off count input and the per-channel counters (1..8).

- CLK  input  1  source clock; all state updates on its rising edge.
- RST  input  1  synchronous reset, active-high.
- TE  input  1  test enable; forces every gate open without touching channel state.
- E  input  N  per-channel enable request, sampled on the CLK rising edge.
- HOLD  input  HOLD_W  hold-off pulse count, shared by all channels.
- Q  output  N  gated clocks.
- ACTIVE  output  N  registered per-channel gate enable (state not IDLE).
- BUSY  output  1  OR of ACTIVE.

## Operation
- Each channel has a 3-state FSM (IDLE, ON, DRAIN) and a HOLD_W-bit counter cnt. The gate enable is gate_en = (state != IDLE).
- IDLE:
  - E=1 moves the channel to ON.
  - Otherwise it stays in IDLE.
- ON:
  - E=1 keeps the channel in ON.
  - E=0 with HOLD=0 moves the channel to IDLE.
  - E=0 with HOLD≠0 moves the channel to DRAIN and loads cnt=HOLD. HOLD is sampled only on this transition.
- DRAIN:
  - E=1 moves the channel to ON. cnt is don't-care.
  - Else cnt==1 moves the channel to IDLE.
  - Else cnt decrements by 1.
- Gated clock: Q[i] = CLK & L[i]. L[i] is a level-sensitive latch with D = gate_en[i] | TE.
  - The latch is transparent while CLK is low and holds while CLK is high.
  - Q never glitches.
  - The latch has no reset.
- TE affects only the latch D input. The FSMs, counters, ACTIVE and BUSY ignore TE.
- ACTIVE[i] = gate_en[i]. BUSY = |ACTIVE. Both come straight from registers with no combinational path from E.
- Channels are fully independent. Only HOLD is shared.

## Timing
- Reset:
  - A rising edge with RST=1 forces all channels to IDLE and cnt=0.
  - ACTIVE=0 and BUSY=0 take effect after that edge.
  - Q=0 from the first CLK low phase after the reset edge, unless TE=1.
  - RST takes priority over E.
- Open latency: E[i]=1 sampled at edge n gives the first Q[i] pulse at the CLK high phase starting at edge n+1.
- Close: E[i]=0 first sampled at edge m (channel in ON) gives exactly HOLD further pulses, at edges m+1..m+HOLD. No pulse occurs at edge m+HOLD+1.
- HOLD=0: Q[i] stops right after the pulse at edge m, the same as the single-channel cell.
- E re-asserted during DRAIN: the channel returns to ON and the pulse train continues without a missing pulse.
- Reset during DRAIN: the remaining hold-off pulses are dropped. The last pulse is the one at the reset edge itself.
- HOLD changed during DRAIN: no effect on the running count.
- HOLD=2^HOLD_W−1: max hold-off. The counter never wraps.
- TE=1: Q[i] pulses every cycle, starting at the first rising edge after TE is seen during a CLK low phase, regardless of RST or state.
- TE deasserted: gating resumes from the current FSM state.

## Test plan
- Reset: hold RST=1 for 3 cycles with E=all 1s and TE=0. Require ACTIVE=0, BUSY=0 and no Q pulses after the first reset edge. Release RST. Require ACTIVE=all 1s one edge later and Q pulses from the following edge.
- Hold-off count: N=4, HOLD=3. Pulse E[0] high for 1 cycle at edge 10. Require Q[0] pulses at edges 11 through 14 (1 + 3 hold-off). Require ACTIVE[0] to fall after edge 14. Require Q[1..3] to stay 0 throughout.
- HOLD=0: repeat the hold-off test. Require exactly 1 Q[0] pulse at edge 11 and ACTIVE[0] high for one cycle only.
- Re-assert during drain: HOLD=5. Drop E[2] at edge 20 and raise it at edge 23. Require a continuous Q[2] train with no gap. Drop E[2] again at edge 30 and require the last pulse at edge 35.
- Reset mid-drain plus HOLD change: HOLD=8. Drop E[1] at edge 40. Change HOLD to 1 at edge 41 and require no effect. Assert RST at edge 43. Require the last Q[1] pulse at edge 43, ACTIVE[1]=0 after edge 43, and BUSY=0.
- Test enable: all channels IDLE, raise TE. Require all Q[*] to pulse every cycle while ACTIVE=0 and BUSY=0. Lower TE. Require Q[*] to stop within one cycle.

Source files
------------

// File: rtl/icg_multi_holdoff.sv
// N-channel glitch-free clock gate. Each channel stays open for HOLD extra pulses after its
// enable drops. A shared test enable forces every gate open.
module icg_multi_holdoff #(
    parameter int N      = 4,
    parameter int HOLD_W = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              TE,
    input  logic [N-1:0]      E,
    input  logic [HOLD_W-1:0] HOLD,
    output logic [N-1:0]      Q,
    output logic [N-1:0]      ACTIVE,
    output logic              BUSY
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ON    = 2'd1,
        DRAIN = 2'd2
    } state_t;

    for (genvar g = 0; g < N; g++) begin : g_ch
        state_t            r_state;
        state_t            w_next;
        logic [HOLD_W-1:0] r_cnt;
        logic [HOLD_W-1:0] w_cntNext;
        logic              r_latch;

        always_ff @(posedge CLK) begin
            if (RST) begin
                r_state <= IDLE;
                r_cnt   <= '0;
            end else begin
                r_state <= w_next;
                r_cnt   <= w_cntNext;
            end
        end

        always_comb begin
            w_next    = r_state;
            w_cntNext = r_cnt;
            case (r_state)
                IDLE: begin
                    if (E[g]) w_next = ON;
                end
                ON: begin
                    if (!E[g]) begin
                        if (HOLD == '0) begin
                            w_next = IDLE;
                        end else begin
                            w_next    = DRAIN;
                            w_cntNext = HOLD;
                        end
                    end
                end
                DRAIN: begin
                    if (E[g]) begin
                        w_next = ON;
                    end else if (r_cnt == HOLD_W'(1)) begin
                        w_next = IDLE;
                    end else begin
                        w_cntNext = r_cnt - HOLD_W'(1);
                    end
                end
                default: w_next = IDLE;
            endcase
        end

        assign ACTIVE[g] = (r_state != IDLE);

        // Transparent only while CLK is low, so the AND below can never glitch.
        always_latch begin
            if (!CLK) r_latch <= ACTIVE[g] | TE;
        end

        assign Q[g] = CLK & r_latch;
    end

    assign BUSY = |ACTIVE;

endmodule

// File: tb/tb_icg_multi_holdoff.sv
// Randomised and directed bench for icg_multi_holdoff against an edge-index model of the
// hold-off window: a channel is open after edge e if E was seen at e, or if e - lastOne <= HOLD latched at the fall.
module tb_icg_multi_holdoff;
    localparam int N      = 4;
    localparam int HOLD_W = 4;

    logic              CLK;
    logic              RST;
    logic              TE;
    logic [N-1:0]      E;
    logic [HOLD_W-1:0] HOLD;
    logic [N-1:0]      Q;
    logic [N-1:0]      ACTIVE;
    logic              BUSY;

    int testsRun  = 0;
    int failCount = 0;

    int         edgeNo = 0;
    int         lastOne [N];
    int         holdCap [N];
    bit         valid   [N];
    logic [N-1:0] expAct  = '0;
    logic [N-1:0] expQ    = '0;
    logic         expBusy = 1'b0;

    icg_multi_holdoff #(.N(N), .HOLD_W(HOLD_W)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .TE     (TE),
        .E      (E),
        .HOLD   (HOLD),
        .Q      (Q),
        .ACTIVE (ACTIVE),
        .BUSY   (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Advance one rising edge, update the model from the sampled inputs, settle 1 time unit.
    task automatic tick();
        logic [N-1:0] prevAct;
        @(posedge CLK);
        prevAct = expAct;
        edgeNo++;
        for (int i = 0; i < N; i++) begin
            if (RST) begin
                valid[i] = 1'b0;
            end else if (E[i]) begin
                valid[i]   = 1'b1;
                lastOne[i] = edgeNo;
            end else if (valid[i] && edgeNo == lastOne[i] + 1) begin
                holdCap[i] = int'(HOLD);
            end
            expAct[i] = valid[i] && (edgeNo == lastOne[i] || edgeNo - lastOne[i] <= holdCap[i]);
        end
        expQ    = prevAct | {N{TE}};
        expBusy = |expAct;
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1; E = '1; TE = 1'b0; HOLD = '0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (k > 0) begin
                if (Q !== expQ) begin failCount++; $display("[TB] FAIL reset_q e%0d got=%b exp=%b", edgeNo, Q, expQ); end
                testsRun++;
            end
            if (ACTIVE !== 4'b0000) begin failCount++; $display("[TB] FAIL reset_active e%0d got=%b exp=0000", edgeNo, ACTIVE); end
            testsRun++;
            if (BUSY !== 1'b0) begin failCount++; $display("[TB] FAIL reset_busy e%0d got=%b exp=0", edgeNo, BUSY); end
            testsRun++;
        end
        RST = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            if (ACTIVE !== 4'b1111) begin failCount++; $display("[TB] FAIL release_active e%0d got=%b exp=1111", edgeNo, ACTIVE); end
            testsRun++;
            if (Q !== ((k == 0) ? 4'b0000 : 4'b1111)) begin failCount++; $display("[TB] FAIL release_q e%0d got=%b exp=%b", edgeNo, Q, (k == 0) ? 4'b0000 : 4'b1111); end
            testsRun++;
        end
        E = '0;
        for (int k = 0; k < 3; k++) tick();
    endtask

    task automatic test_holdoff(input int hold);
        int pulses0 = 0;
        int otherPulses = 0;
        HOLD = HOLD_W'(hold);
        E = 4'b0001;
        tick();
        E = 4'b0000;
        for (int k = 0; k < hold + 4; k++) begin
            tick();
            if (Q[0]) pulses0++;
            if (Q[3:1] != 3'b000) otherPulses++;
            if (Q !== expQ) begin failCount++; $display("[TB] FAIL holdoff%0d_q e%0d got=%b exp=%b", hold, edgeNo, Q, expQ); end
            testsRun++;
            if (ACTIVE !== expAct) begin failCount++; $display("[TB] FAIL holdoff%0d_active e%0d got=%b exp=%b", hold, edgeNo, ACTIVE, expAct); end
            testsRun++;
            if (ACTIVE[0] !== (k < hold)) begin failCount++; $display("[TB] FAIL holdoff%0d_active0 e%0d got=%b exp=%b", hold, edgeNo, ACTIVE[0], k < hold); end
            testsRun++;
        end
        if (pulses0 != hold + 1) begin failCount++; $display("[TB] FAIL holdoff%0d_count got=%0d exp=%0d", hold, pulses0, hold + 1); end
        testsRun++;
        if (otherPulses != 0) begin failCount++; $display("[TB] FAIL holdoff%0d_others got=%0d exp=0", hold, otherPulses); end
        testsRun++;
    endtask

    task automatic test_drain_reassert();
        int pulses = 0;
        int gaps = 0;
        bit seen = 1'b0;
        bit ended = 1'b0;
        HOLD = 4'd5;
        for (int j = 0; j < 25; j++) begin
            E = ((j < 4) || (j >= 7 && j < 14)) ? 4'b0100 : 4'b0000;
            tick();
            if (Q[2]) begin
                pulses++;
                if (ended) gaps++;
                seen = 1'b1;
            end else if (seen) begin
                ended = 1'b1;
            end
            if (Q !== expQ) begin failCount++; $display("[TB] FAIL reassert_q e%0d got=%b exp=%b", edgeNo, Q, expQ); end
            testsRun++;
            if (ACTIVE !== expAct) begin failCount++; $display("[TB] FAIL reassert_active e%0d got=%b exp=%b", edgeNo, ACTIVE, expAct); end
            testsRun++;
        end
        if (pulses != 19) begin failCount++; $display("[TB] FAIL reassert_count got=%0d exp=19", pulses); end
        testsRun++;
        if (gaps != 0) begin failCount++; $display("[TB] FAIL reassert_gap got=%0d exp=0", gaps); end
        testsRun++;
    endtask

    task automatic test_reset_drain();
        int pulses = 0;
        HOLD = 4'd8;
        for (int j = 0; j < 11; j++) begin
            E    = (j < 4) ? 4'b0010 : 4'b0000;
            if (j == 5) HOLD = 4'd1;
            RST  = (j == 7);
            tick();
            if (Q[1]) pulses++;
            if (Q !== expQ) begin failCount++; $display("[TB] FAIL rstdrain_q e%0d got=%b exp=%b", edgeNo, Q, expQ); end
            testsRun++;
            if (ACTIVE !== expAct) begin failCount++; $display("[TB] FAIL rstdrain_active e%0d got=%b exp=%b", edgeNo, ACTIVE, expAct); end
            testsRun++;
            if (j >= 7 && BUSY !== 1'b0) begin failCount++; $display("[TB] FAIL rstdrain_busy e%0d got=%b exp=0", edgeNo, BUSY); end
            testsRun++;
        end
        RST = 1'b0;
        if (pulses != 7) begin failCount++; $display("[TB] FAIL rstdrain_count got=%0d exp=7", pulses); end
        testsRun++;
    endtask

    task automatic test_te();
        E = '0; HOLD = '0; RST = 1'b0;
        tick();
        TE = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (Q !== 4'b1111) begin failCount++; $display("[TB] FAIL te_q e%0d got=%b exp=1111", edgeNo, Q); end
            testsRun++;
            if (ACTIVE !== 4'b0000 || BUSY !== 1'b0) begin failCount++; $display("[TB] FAIL te_status e%0d got=%b/%b exp=0000/0", edgeNo, ACTIVE, BUSY); end
            testsRun++;
        end
        TE = 1'b0;
        tick();
        if (Q !== 4'b0000) begin failCount++; $display("[TB] FAIL te_off_q e%0d got=%b exp=0000", edgeNo, Q); end
        testsRun++;
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            for (int i = 0; i < N; i++) if ($urandom_range(0, 3) == 0) E[i] = ~E[i];
            HOLD = HOLD_W'($urandom_range(0, 15));
            RST  = ($urandom_range(0, 59) == 0);
            TE   = ($urandom_range(0, 29) == 0);
            tick();
            if (Q !== expQ) begin failCount++; $display("[TB] FAIL rand_q e%0d got=%b exp=%b", edgeNo, Q, expQ); end
            testsRun++;
            if (ACTIVE !== expAct) begin failCount++; $display("[TB] FAIL rand_active e%0d got=%b exp=%b", edgeNo, ACTIVE, expAct); end
            testsRun++;
            if (BUSY !== expBusy) begin failCount++; $display("[TB] FAIL rand_busy e%0d got=%b exp=%b", edgeNo, BUSY, expBusy); end
            testsRun++;
        end
        RST = 1'b0; TE = 1'b0; E = '0;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            lastOne[i] = 0;
            holdCap[i] = 0;
            valid[i]   = 1'b0;
        end
        RST = 1'b1; TE = 1'b0; E = '0; HOLD = '0;
        test_reset();
        test_holdoff(3);
        test_holdoff(0);
        test_holdoff(15);
        test_drain_reassert();
        test_reset_drain();
        test_te();
        test_random();
        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
